// File: rtl/mem_bus_pkg.sv
// Shared types for the simple req/resp memory bus and its burst master.
package mem_bus_pkg;

    localparam logic FUNC_RD = 1'b0;
    localparam logic FUNC_WR = 1'b1;

    // One single-beat bus request as presented on out_req_bits_*.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        func;
        logic [3:0]  wstrb;
        logic        is_aligned;
        logic        is_cached;
    } mem_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_REQ,
        ST_RESP
    } master_state_t;

endpackage

// File: rtl/mem_master_timer.sv
// Per-beat watchdog for mem_burst_master: cleared by load, counts while run,
// saturates at LIMIT-1 and flags expired on every running cycle at that count.
module mem_master_timer #(
    parameter int LIMIT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam int               CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt;

    // Count running cycles since the last load; hold at LAST so expiry stays asserted.
    always_ff @(posedge clock) begin
        if (!reset)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (run && cnt != LAST)
            cnt <= cnt + 1'b1;
    end

    assign expired = run && (cnt == LAST);

endmodule

// File: rtl/mem_burst_master.sv
// Burst master: expands one command into sequential single-beat bus requests.
// Optional per-beat timeout is built when MEM_MASTER_TIMEOUT_EN is defined.
module mem_burst_master
    import mem_bus_pkg::*;
#(
    parameter int   LEN_W          = 8,
    parameter logic CACHED         = 1'b0,
    parameter int   TIMEOUT_CYCLES = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_func,
    input  logic [3:0]       cmd_wstrb,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    input  logic [31:0]      wdata,
    output logic             rdata_valid,
    input  logic             rdata_ready,
    output logic [31:0]      rdata,
    output logic             done,
    output logic             done_err,
    output logic             out_req_valid,
    input  logic             out_req_ready,
    output logic             out_req_bits_is_aligned,
    output logic             out_req_bits_is_cached,
    output logic [31:0]      out_req_bits_addr,
    output logic [31:0]      out_req_bits_data,
    output logic             out_req_bits_func,
    output logic [3:0]       out_req_bits_wstrb,
    input  logic             out_resp_valid,
    output logic             out_resp_ready,
    input  logic [31:0]      out_resp_bits_data
);

    master_state_t    state;
    mem_req_t         req;
    logic [LEN_W-1:0] beats_left;
    logic             resp_hs;
    logic             timeout_hit;
    logic             idle_drain;

`ifdef MEM_MASTER_TIMEOUT_EN
    logic enter_req;

    // Every path into REQ restarts the per-beat wait budget.
    assign enter_req = (state == ST_IDLE && cmd_valid && cmd_func == FUNC_RD) ||
                       (state == ST_LOAD && wdata_valid) ||
                       (state == ST_RESP && resp_hs && beats_left != '0 && req.func == FUNC_RD);

    mem_master_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (enter_req),
        .run     (state == ST_REQ || state == ST_RESP),
        .expired (timeout_hit)
    );

    // A response arriving after an abort is swallowed while idle.
    assign idle_drain = 1'b1;
`else
    assign timeout_hit = 1'b0;
    assign idle_drain  = 1'b0;
`endif

    assign resp_hs = (state == ST_RESP) && out_resp_valid && out_resp_ready;

    // Burst sequencing: latch the command, walk beats, pulse done on the way back to IDLE.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            req        <= '0;
            beats_left <= '0;
            done       <= 1'b0;
            done_err   <= 1'b0;
        end else begin
            done     <= 1'b0;
            done_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        req.addr       <= cmd_addr;
                        req.func       <= cmd_func;
                        req.wstrb      <= (cmd_func == FUNC_WR) ? cmd_wstrb : 4'h0;
                        req.is_aligned <= (cmd_addr[1:0] == 2'b00);
                        req.is_cached  <= CACHED;
                        beats_left     <= cmd_len;
                        state          <= (cmd_func == FUNC_WR) ? ST_LOAD : ST_REQ;
                    end
                end
                ST_LOAD: begin
                    if (wdata_valid) begin
                        req.data <= wdata;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (out_req_ready) begin
                        state <= ST_RESP;
                    end else if (timeout_hit) begin
                        state    <= ST_IDLE;
                        done     <= 1'b1;
                        done_err <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_hs) begin
                        if (beats_left == '0) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end else begin
                            req.addr   <= req.addr + 32'd4;
                            beats_left <= beats_left - 1'b1;
                            state      <= (req.func == FUNC_WR) ? ST_LOAD : ST_REQ;
                        end
                    end else if (timeout_hit) begin
                        state    <= ST_IDLE;
                        done     <= 1'b1;
                        done_err <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready               = (state == ST_IDLE);
    assign wdata_ready             = (state == ST_LOAD);
    assign out_req_valid           = (state == ST_REQ);
    assign out_req_bits_addr       = req.addr;
    assign out_req_bits_data       = req.data;
    assign out_req_bits_func       = req.func;
    assign out_req_bits_wstrb      = req.wstrb;
    assign out_req_bits_is_aligned = req.is_aligned;
    assign out_req_bits_is_cached  = req.is_cached;

    // Read responses pass straight through to the rdata stream with no added latency.
    assign rdata          = out_resp_bits_data;
    assign rdata_valid    = (state == ST_RESP) && (req.func == FUNC_RD) && out_resp_valid;
    assign out_resp_ready = (state == ST_RESP) ? ((req.func == FUNC_RD) ? rdata_ready : 1'b1)
                                               : ((state == ST_IDLE) && idle_drain);

endmodule
